sha256_round_engine: RTL
========================

// Module: sha256_round_engine
// PURPOSE
// - SHA-256 compression engine driving the H-register accumulators (H1..H8). Per compression it
//   loads h_init, runs 64 rounds at one round per clock, then presents final working variables a..h.
// - Also drives the shared 2-bit Block phase bus the accumulators sequence on:
//   0 = job start / IV reload, 1 = header block 1 done, 2 = header block 2 done, 3 = second-hash done.
// - Sits between the job controller (supplies message blocks) and the accumulator bank (adds our outputs).
// PARAMETERS
// - ROUNDS      64   rounds per compression; fixed by SHA-256, a parameter only for reduced-round sim
// - WORD_W      32   word width; only 32 is supported
// PORTS
// - clk          in   1    rising-edge clock
// - rst          in   1    synchronous active-high reset
// - start        in   1    request a compression; accepted only when ready=1
// - msg_block    in   512  message words W0..W15; W0 in [511:480]; sampled in the start cycle
// - h_init       in   256  initial a..h; a in [255:224]; sampled in the start cycle
// - ready        out  1    idle; start will be accepted
// - done         out  1    one-cycle pulse: final a..h valid and Block just advanced
// - Block        out  2    phase bus to accumulators
// - a_out..h_out out  32x8 final working variables; held until the next done
// BEHAVIOUR
// - Reset: ready=1, done=0, Block=0, a_out..h_out=0, round counter=0, FSM=IDLE.
//   Reset wins over every other input, including mid-compression; partial results are discarded.
// - FSM IDLE -> LOAD -> ROUND -> FINISH -> IDLE.
//   - IDLE: ready=1. start=1: latch msg_block/h_init, go to LOAD, ready=0.
//     If Block==3 when start is accepted, Block <= 0 in that same edge (new job; accumulators reload IV).
//   - LOAD, 1 cycle: a..h <= h_init; the W window is filled with W0..W15; t <= 0.
//   - ROUND, ROUNDS cycles, t = 0..63:
//     - T1 = h + S1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = S0(a) + Maj(a,b,c).
//     - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2; all sums mod 2^32, carries dropped.
//     - W[t] for t>=16 comes from the schedule window:
//       W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
//   - FINISH, 1 cycle: a_out..h_out <= a..h; done=1; Block <= Block+1, saturating at 3
//     (a start from Block 3 already restarted at 0). Back to IDLE, ready=1 on the next cycle.
// - Latency: start edge to done = 66 clocks (1 LOAD + 64 ROUND + 1 FINISH). Back-to-back period = 67.
// - Block changes only at the FINISH edge or the new-job start edge. It is stable otherwise, so the
//   accumulators' source toggle sees exactly one update per phase.
// - start while ready=0 is ignored: no queueing, no error flag.
// - Outputs are the raw working variables, NOT a..h + H. The accumulators perform the final add.
// - Only one compression is in flight. h_init/msg_block may change freely after the start cycle.
// STRUCTURE
// - sha256_pkg (shared with the accumulators and the job controller):
//   - K[0:63] constant table; IV constants H0..H7 (0x6a09e667 .. 0x5be0cd19);
//   - Block phase localparams BLK_START=0, BLK_HDR1=1, BLK_HDR2=2, BLK_DBL=3;
//   - functions Ch, Maj, S0, S1, s0, s1.
// - One sub-module: sha256_msg_schedule.
//   - 16x32 shift window with ports load, msg_block, advance, w_t.
//   - Presents W[t] combinationally and shifts in the new word on advance.
// - FSM, round counter, working registers and output registers live in this module.
// TESTING
// - "abc" padded single block, h_init=IV, start pulse: done exactly 66 clk later; Block 0->1;
//   a_out=0x506e3058 and h_out=0x961f4894 (IV + out = 0xba7816bf / 0xf20015ad).
// - Three back-to-back starts with ready honoured: Block steps 1,2,3, each step coincident with done.
//   A fourth start drives Block to 0 at the accept edge, then Block=1 at its done.
// - start held high during ROUND: no second compression.
//   Outputs and Block match a single-start run; ready low for 66 cycles after the accept edge.
// - rst asserted at round t=30: next cycle ready=1, Block=0, outputs 0, no done pulse.
//   A subsequent "abc" run reproduces the first scenario exactly.
// - All-ones msg_block with h_init all 0xffffffff: results match the reference model.
//   This checks every mod-2^32 wrap in T1/T2 and the schedule sums.
// - Randomised 200 blocks vs a C SHA-256 model.
//   Compare a..h at each done, and check Block never changes outside done/accept edges.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the round engine, the accumulators and the job controller:
// round constants, IV, Block phase encodings and the round/schedule logic functions.
package sha256_pkg;

    localparam logic [1:0] BLK_START = 2'd0;
    localparam logic [1:0] BLK_HDR1  = 2'd1;
    localparam logic [1:0] BLK_HDR2  = 2'd2;
    localparam logic [1:0] BLK_DBL   = 2'd3;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINISH} state_t;

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word message schedule window: presents W[t] from the head and shifts in W[t+16] on advance.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         load,
    input  logic [511:0] msg_block,
    input  logic         advance,
    output logic [31:0]  w_t
);

    logic [31:0] win [16];
    logic [31:0] w_new;

    // win[0] holds W[t]; the new word is W[t+16] built from W[t+14], W[t+9], W[t+1], W[t].
    assign w_t   = win[0];
    assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

    // NOTE: the window has no reset; it is always fully overwritten by load before it is read.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= msg_block[511 - 32*i -: 32];
            end
        end else if (advance) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i + 1];
            end
            win[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: loads h_init, runs ROUNDS rounds at one per clock, presents the raw
// working variables a..h and sequences the Block phase bus for the downstream accumulators.
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [511:0]      msg_block,
    input  logic [255:0]      h_init,
    output logic              ready,
    output logic              done,
    output logic [1:0]        Block,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] b_out,
    output logic [WORD_W-1:0] c_out,
    output logic [WORD_W-1:0] d_out,
    output logic [WORD_W-1:0] e_out,
    output logic [WORD_W-1:0] f_out,
    output logic [WORD_W-1:0] g_out,
    output logic [WORD_W-1:0] h_out
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    state_t           state, state_next;
    logic [CNT_W-1:0] t;
    logic [511:0]     msg_q;
    logic [255:0]     init_q;
    logic [31:0]      a, b, c, d, e, f, g, h;
    logic [31:0]      w_t, t1, t2;
    logic             accept, last_round, sched_load, sched_advance;

    assign ready         = (state == ST_IDLE);
    assign accept        = ready && start;
    assign last_round    = (t == CNT_W'(ROUNDS - 1));
    assign sched_load    = (state == ST_LOAD);
    assign sched_advance = (state == ST_ROUND);

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + K[t] + w_t;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    sha256_msg_schedule u_sched (
        .clk       (clk),
        .load      (sched_load),
        .msg_block (msg_q),
        .advance   (sched_advance),
        .w_t       (w_t)
    );

    // NOTE: next-state is defaulted to the current state first, so no path leaves it unassigned.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_ROUND;
            ST_ROUND:  if (last_round) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Block moves only at a new-job accept from BLK_DBL or at FINISH, so each phase is seen once.
    always_ff @(posedge clk) begin
        if (rst) begin
            t     <= '0;
            done  <= 1'b0;
            Block <= BLK_START;
            a_out <= '0;
            b_out <= '0;
            c_out <= '0;
            d_out <= '0;
            e_out <= '0;
            f_out <= '0;
            g_out <= '0;
            h_out <= '0;
        end else begin
            done <= (state == ST_FINISH);
            if (sched_load)         t <= '0;
            else if (sched_advance) t <= t + CNT_W'(1);
            if (accept && Block == BLK_DBL)               Block <= BLK_START;
            else if (state == ST_FINISH && Block != BLK_DBL) Block <= Block + 2'd1;
            if (state == ST_FINISH) begin
                a_out <= a;
                b_out <= b;
                c_out <= c;
                d_out <= d;
                e_out <= e;
                f_out <= f;
                g_out <= g;
                h_out <= h;
            end
        end
    end

    // Job inputs and working variables are only meaningful between LOAD and FINISH.
    always_ff @(posedge clk) begin
        if (accept) begin
            msg_q  <= msg_block;
            init_q <= h_init;
        end
        if (sched_load) begin
            {a, b, c, d, e, f, g, h} <= init_q;
        end else if (sched_advance) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
        end
    end

endmodule
